// File: rtl/game_setup_ctrl.sv
// Game settings sequencer: latches a difficulty level, derives board geometry with a
// 5-step shift-add multiplier, then publishes a stable configuration for the game lifecycle.
module game_setup_ctrl #(
    parameter int unsigned H_RES = 1024,
    parameter int unsigned V_RES = 768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  level_sel,
    input  logic        level_valid,
    input  logic        game_end,
    input  logic        restart,
    output logic [4:0]  button_num,
    output logic [6:0]  button_size,
    output logic [9:0]  board_size,
    output logic [10:0] board_xpos,
    output logic [10:0] board_ypos,
    output logic [6:0]  mines,
    output logic        cfg_valid,
    output logic        game_active,
    output logic        busy
);

    localparam int unsigned NUM_W   = 5;
    localparam int unsigned SIZE_W  = 7;
    localparam int unsigned BOARD_W = 10;
    localparam int unsigned POS_W   = 11;
    localparam int unsigned MINES_W = 7;
    localparam int unsigned ACC_W   = 12;
    localparam int unsigned CNT_W   = 3;

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(NUM_W - 1);
    localparam logic [ACC_W-1:0] H_RES12  = ACC_W'(H_RES);
    localparam logic [ACC_W-1:0] V_RES12  = ACC_W'(V_RES);

    typedef enum logic [2:0] {IDLE, MUL, POS, ACTIVE, DONE} state_t;

    state_t state, state_n;

    logic [NUM_W-1:0]   lat_num, tbl_num;
    logic [SIZE_W-1:0]  lat_size, tbl_size;
    logic [MINES_W-1:0] lat_mines, tbl_mines;
    logic [ACC_W-1:0]   acc, board12;
    logic [CNT_W-1:0]   cnt;
    logic [BOARD_W-1:0] geo_board;
    logic [POS_W-1:0]   geo_x, geo_y, xpos_c, ypos_c;

    logic [NUM_W-1:0]   button_num_n;
    logic [SIZE_W-1:0]  button_size_n;
    logic [BOARD_W-1:0] board_size_n;
    logic [POS_W-1:0]   board_xpos_n, board_ypos_n;
    logic [MINES_W-1:0] mines_n;
    logic               cfg_valid_n, game_active_n, busy_n;

    // Difficulty table lookup
    always_comb begin
        tbl_num   = '0;
        tbl_size  = '0;
        tbl_mines = '0;
        case (level_sel)
            2'd1: begin tbl_num = NUM_W'(8);  tbl_size = SIZE_W'(50); tbl_mines = MINES_W'(10); end
            2'd2: begin tbl_num = NUM_W'(16); tbl_size = SIZE_W'(40); tbl_mines = MINES_W'(40); end
            2'd3: begin tbl_num = NUM_W'(24); tbl_size = SIZE_W'(30); tbl_mines = MINES_W'(99); end
            default: ;
        endcase
    end

    // Centring; a board larger than the screen pins to the origin
    assign board12 = ACC_W'(acc[BOARD_W-1:0]);
    assign xpos_c  = (board12 > H_RES12) ? '0 : POS_W'((H_RES12 - board12) >> 1);
    assign ypos_c  = (board12 > V_RES12) ? '0 : POS_W'((V_RES12 - board12) >> 1);

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            button_num  <= '0;
            button_size <= '0;
            board_size  <= '0;
            board_xpos  <= '0;
            board_ypos  <= '0;
            mines       <= '0;
            cfg_valid   <= 1'b0;
            game_active <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            button_num  <= button_num_n;
            button_size <= button_size_n;
            board_size  <= board_size_n;
            board_xpos  <= board_xpos_n;
            board_ypos  <= board_ypos_n;
            mines       <= mines_n;
            cfg_valid   <= cfg_valid_n;
            game_active <= game_active_n;
            busy        <= busy_n;
        end
    end

    // Next-state logic; POS spends two cycles (compute, then publish)
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (level_valid && level_sel != 2'd0) state_n = MUL;
            MUL:     if (cnt == MUL_LAST) state_n = POS;
            POS:     if (cnt != '0) state_n = ACTIVE;
            ACTIVE:  if (restart) state_n = IDLE;
                     else if (game_end) state_n = DONE;
            DONE:    if (restart) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output next values: hold by default, change only on transitions
    always_comb begin
        button_num_n  = button_num;
        button_size_n = button_size;
        board_size_n  = board_size;
        board_xpos_n  = board_xpos;
        board_ypos_n  = board_ypos;
        mines_n       = mines;
        cfg_valid_n   = cfg_valid;
        game_active_n = game_active;
        busy_n        = (state_n == MUL) || (state_n == POS);
        if (state == POS && state_n == ACTIVE) begin
            button_num_n  = lat_num;
            button_size_n = lat_size;
            board_size_n  = geo_board;
            board_xpos_n  = geo_x;
            board_ypos_n  = geo_y;
            mines_n       = lat_mines;
            cfg_valid_n   = 1'b1;
            game_active_n = 1'b1;
        end
        if (state_n == DONE) game_active_n = 1'b0;
        if (state_n == IDLE) begin
            button_num_n  = '0;
            button_size_n = '0;
            board_size_n  = '0;
            board_xpos_n  = '0;
            board_ypos_n  = '0;
            mines_n       = '0;
            cfg_valid_n   = 1'b0;
            game_active_n = 1'b0;
        end
    end

    // Datapath: level latch, shift-add multiplier, geometry registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_num   <= '0;
            lat_size  <= '0;
            lat_mines <= '0;
            acc       <= '0;
            cnt       <= '0;
            geo_board <= '0;
            geo_x     <= '0;
            geo_y     <= '0;
        end else begin
            case (state)
                IDLE: if (state_n == MUL) begin
                    lat_num   <= tbl_num;
                    lat_size  <= tbl_size;
                    lat_mines <= tbl_mines;
                    acc       <= '0;
                    cnt       <= '0;
                end
                MUL: begin
                    if (lat_num[cnt]) acc <= acc + (ACC_W'(lat_size) << cnt);
                    cnt <= (cnt == MUL_LAST) ? '0 : cnt + CNT_W'(1);
                end
                POS: begin
                    if (cnt == '0) begin
                        geo_board <= acc[BOARD_W-1:0];
                        geo_x     <= xpos_c;
                        geo_y     <= ypos_c;
                        cnt       <= CNT_W'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_setup_ctrl.sv
// Scoreboard bench for game_setup_ctrl: expected configurations are queued at selection
// time and compared when cfg_valid rises; lifecycle and reset cases checked inline.
module tb_game_setup_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  level_sel;
    logic        level_valid;
    logic        game_end;
    logic        restart;
    logic [4:0]  button_num;
    logic [6:0]  button_size;
    logic [9:0]  board_size;
    logic [10:0] board_xpos;
    logic [10:0] board_ypos;
    logic [6:0]  mines;
    logic        cfg_valid;
    logic        game_active;
    logic        busy;

    typedef struct {
        int num;
        int size;
        int board;
        int x;
        int y;
        int mines;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    game_setup_ctrl #(.H_RES(1024), .V_RES(768)) dut (
        .clk(clk), .rst(rst),
        .level_sel(level_sel), .level_valid(level_valid),
        .game_end(game_end), .restart(restart),
        .button_num(button_num), .button_size(button_size), .board_size(board_size),
        .board_xpos(board_xpos), .board_ypos(board_ypos), .mines(mines),
        .cfg_valid(cfg_valid), .game_active(game_active), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int sel);
        exp_t e;
        e.num = 0; e.size = 0; e.mines = 0;
        case (sel)
            1: begin e.num = 8;  e.size = 50; e.mines = 10; end
            2: begin e.num = 16; e.size = 40; e.mines = 40; end
            3: begin e.num = 24; e.size = 30; e.mines = 99; end
            default: ;
        endcase
        e.board = e.num * e.size;
        e.x = (e.board > 1024) ? 0 : (1024 - e.board) / 2;
        e.y = (e.board > 768)  ? 0 : (768 - e.board) / 2;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".button_num"},  button_num,  0);
        check({tag, ".button_size"}, button_size, 0);
        check({tag, ".board_size"},  board_size,  0);
        check({tag, ".board_xpos"},  board_xpos,  0);
        check({tag, ".board_ypos"},  board_ypos,  0);
        check({tag, ".mines"},       mines,       0);
        check({tag, ".cfg_valid"},   cfg_valid,   0);
        check({tag, ".game_active"}, game_active, 0);
        check({tag, ".busy"},        busy,        0);
    endtask

    // Select a level; optionally inject a second (sel=1) strobe on edge inject_edge
    task automatic run_level(input int sel, input int inject_edge);
        exp_t e;
        int   lat;
        string p;
        p = $sformatf("L%0d", sel);
        sb_q.push_back(model(sel));
        level_sel   = 2'(sel);
        level_valid = 1'b1;
        tick();
        level_valid = 1'b0;
        level_sel   = 2'd0;
        check({p, ".busy_e0"}, busy, 1);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            if (k == inject_edge) begin
                level_sel   = 2'd1;
                level_valid = 1'b1;
            end
            tick();
            level_valid = 1'b0;
            level_sel   = 2'd0;
            if (cfg_valid) lat = k;
            else check($sformatf("%s.busy_e%0d", p, k), busy, 1);
        end
        check({p, ".latency"}, lat, 7);
        if (sb_q.size() == 0) begin
            check({p, ".sb_underflow"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            check({p, ".button_num"},  button_num,  e.num);
            check({p, ".button_size"}, button_size, e.size);
            check({p, ".board_size"},  board_size,  e.board);
            check({p, ".board_xpos"},  board_xpos,  e.x);
            check({p, ".board_ypos"},  board_ypos,  e.y);
            check({p, ".mines"},       mines,       e.mines);
        end
        check({p, ".cfg_valid"},   cfg_valid,   1);
        check({p, ".game_active"}, game_active, 1);
        check({p, ".busy_done"},   busy,        0);
    endtask

    task automatic pulse(input logic ge, input logic rs);
        game_end = ge;
        restart  = rs;
        tick();
        game_end = 1'b0;
        restart  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; level_sel = 2'd0; level_valid = 1'b0; game_end = 1'b0; restart = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_idle("reset");

        // level 0 is not a selection
        level_valid = 1'b1;
        tick();
        level_valid = 1'b0;
        tick();
        check_idle("sel0");

        run_level(1, 0);
        pulse(1'b0, 1'b1);
        check_idle("restart_easy");

        // second strobe during MUL must not disturb the hard result
        run_level(3, 3);
        repeat (3) tick();
        check("hard.hold_board", board_size, 720);
        check("hard.hold_busy", busy, 0);
        pulse(1'b0, 1'b1);
        check_idle("restart_hard");

        // lifecycle: ACTIVE -> DONE -> IDLE -> ACTIVE
        run_level(2, 0);
        pulse(1'b1, 1'b0);
        check("done.game_active", game_active, 0);
        check("done.cfg_valid", cfg_valid, 1);
        check("done.board_size", board_size, 640);
        check("done.board_xpos", board_xpos, 192);
        level_sel = 2'd3; level_valid = 1'b1;
        pulse(1'b1, 1'b0);
        level_sel = 2'd0; level_valid = 1'b0;
        repeat (2) tick();
        check("done.hold_board", board_size, 640);
        check("done.hold_ypos", board_ypos, 64);
        check("done.hold_cfg", cfg_valid, 1);
        check("done.hold_busy", busy, 0);
        pulse(1'b0, 1'b1);
        check_idle("restart_done");
        run_level(1, 0);

        // restart beats game_end on the same edge
        pulse(1'b1, 1'b1);
        check_idle("end_restart");
        tick();
        check_idle("end_restart_next");

        // reset at E4 in the middle of MUL
        level_sel = 2'd1; level_valid = 1'b1;
        tick();
        level_sel = 2'd0; level_valid = 1'b0;
        repeat (3) tick();
        check("mid.busy_e3", busy, 1);
        rst = 1'b1;
        tick();
        check_idle("rst_mid");
        rst = 1'b0;
        tick();
        check_idle("rst_mid_rel");
        run_level(1, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
